// File: rtl/mctrl_pkg.sv
// mctrl_pkg: shared encodings for the multicycle MIPS control unit.
//   state_t    - FSM state encodings (12-14 unused, 15 = ILLEGAL)
//   OP_*       - instruction opcode field values (Opcode = IR[31:26])
//   ALU_*      - ALUOp codes driven to the ALU control
//   SRCB_*     - ALUSrcB mux selects
//   PCS_*      - PCSource mux selects
//   decode_next- DECODE-state dispatch from opcode to the first execute state
package mctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_LWB     = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXE    = 4'd6,
        S_RWB     = 4'd7,
        S_IEXE    = 4'd8,
        S_IWB     = 4'd9,
        S_BR      = 4'd10,
        S_JMP     = 4'd11,
        S_ILLEGAL = 4'd15
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_LUI   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_ILL   = 3'b111;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:                      return S_MEMADR;
            OP_R:                              return S_REXE;
            OP_ADDI, OP_ADDIU, OP_LUI, OP_ORI: return S_IEXE;
            OP_BEQ:                            return S_BR;
            OP_J:                              return S_JMP;
            default:                           return S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mctrl_dec.sv
// mctrl_dec: combinational state/opcode to control-signal decoder.
//   i_rst       - forces all memory/PC/register strobes low
//   i_mem_ready - gates the FETCH-state IR/PC load
//   i_state     - current FSM state
//   i_opcode    - instruction opcode, selects ALU op / extension in IEXE
//   o_*         - datapath control signals
module mctrl_dec
    import mctrl_pkg::*;
(
    input  logic       i_rst,
    input  logic       i_mem_ready,
    input  logic [3:0] i_state,
    input  logic [5:0] i_opcode,
    output logic       o_pcwrite,
    output logic       o_branch,
    output logic [1:0] o_pcsource,
    output logic       o_iord,
    output logic       o_memread,
    output logic       o_memwrite,
    output logic       o_irwrite,
    output logic       o_regdst,
    output logic       o_memtoreg,
    output logic       o_regwrite,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [2:0] o_aluop,
    output logic       o_ext_op,
    output logic       o_illegal
);

    always_comb begin
        o_pcwrite  = 1'b0;
        o_branch   = 1'b0;
        o_pcsource = PCS_ALU;
        o_iord     = 1'b0;
        o_memread  = 1'b0;
        o_memwrite = 1'b0;
        o_irwrite  = 1'b0;
        o_regdst   = 1'b0;
        o_memtoreg = 1'b0;
        o_regwrite = 1'b0;
        o_alusrca  = 1'b0;
        o_alusrcb  = SRCB_RT;
        o_aluop    = ALU_ADD;
        o_ext_op   = 1'b0;
        o_illegal  = 1'b0;
        case (i_state)
            S_FETCH: begin
                o_memread = 1'b1;
                o_alusrcb = SRCB_FOUR;
                o_irwrite = i_mem_ready;
                o_pcwrite = i_mem_ready;
            end
            S_DECODE: begin
                o_alusrcb = SRCB_IMM4;
                o_ext_op  = 1'b1;
            end
            S_MEMADR: begin
                o_alusrca = 1'b1;
                o_alusrcb = SRCB_IMM;
                o_ext_op  = 1'b1;
            end
            S_MEMRD: begin
                o_memread = 1'b1;
                o_iord    = 1'b1;
            end
            S_LWB: begin
                o_regwrite = 1'b1;
                o_memtoreg = 1'b1;
            end
            S_MEMWR: begin
                o_memwrite = 1'b1;
                o_iord     = 1'b1;
            end
            S_REXE: begin
                o_alusrca = 1'b1;
                o_aluop   = ALU_FUNCT;
            end
            S_RWB: begin
                o_regwrite = 1'b1;
                o_regdst   = 1'b1;
            end
            S_IEXE: begin
                o_alusrca = 1'b1;
                o_alusrcb = SRCB_IMM;
                o_aluop   = (i_opcode == OP_LUI) ? ALU_LUI :
                            (i_opcode == OP_ORI) ? ALU_OR  : ALU_ADD;
                o_ext_op  = (i_opcode != OP_LUI) && (i_opcode != OP_ORI);
            end
            S_IWB: begin
                o_regwrite = 1'b1;
            end
            S_BR: begin
                o_alusrca  = 1'b1;
                o_aluop    = ALU_SUB;
                o_branch   = 1'b1;
                o_pcsource = PCS_ALUOUT;
            end
            S_JMP: begin
                o_pcwrite  = 1'b1;
                o_pcsource = PCS_JUMP;
            end
            S_ILLEGAL: begin
                o_aluop   = ALU_ILL;
                o_illegal = 1'b1;
            end
            default: ;
        endcase
        // Reset aborts whatever is in flight: no side-effecting strobe may escape.
        if (i_rst) begin
            o_memread  = 1'b0;
            o_memwrite = 1'b0;
            o_irwrite  = 1'b0;
            o_pcwrite  = 1'b0;
            o_branch   = 1'b0;
            o_regwrite = 1'b0;
        end
    end

endmodule

// File: rtl/mctrl.sv
// mctrl: multicycle MIPS control unit (Moore FSM).
//   clk, rst   - clock, synchronous active-high reset
//   Opcode     - IR[31:26]; Zero - ALU zero flag; mem_ready - memory done
//   PCWrite/Branch/PCSource, IorD/MemRead/MemWrite/IRWrite,
//   RegDst/MemtoReg/RegWrite, ALUSrcA/ALUSrcB/ALUOp/Ext_op - datapath controls
//   illegal    - sticky illegal-opcode flag; state - current state for debug
module mctrl
    import mctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       Ext_op,
    output logic       illegal,
    output logic [3:0] state
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    // Zero is combined with Branch by the datapath PC-load gate, not here.
    logic       w_unused_zero;

    assign w_unused_zero = Zero;
    assign state         = r_state;

    always_comb begin
        w_next = S_ILLEGAL;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = decode_next(Opcode);
            S_MEMADR: w_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = mem_ready ? S_LWB : S_MEMRD;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_REXE:   w_next = S_RWB;
            S_IEXE:   w_next = S_IWB;
            S_LWB, S_RWB, S_IWB, S_BR, S_JMP: w_next = S_FETCH;
            // ILLEGAL and the unused encodings 12-14 all trap in ILLEGAL.
            default:  w_next = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    mctrl_dec u_dec (
        .i_rst       (rst),
        .i_mem_ready (mem_ready),
        .i_state     (r_state),
        .i_opcode    (Opcode),
        .o_pcwrite   (PCWrite),
        .o_branch    (Branch),
        .o_pcsource  (PCSource),
        .o_iord      (IorD),
        .o_memread   (MemRead),
        .o_memwrite  (MemWrite),
        .o_irwrite   (IRWrite),
        .o_regdst    (RegDst),
        .o_memtoreg  (MemtoReg),
        .o_regwrite  (RegWrite),
        .o_alusrca   (ALUSrcA),
        .o_alusrcb   (ALUSrcB),
        .o_aluop     (ALUOp),
        .o_ext_op    (Ext_op),
        .o_illegal   (illegal)
    );

endmodule

// File: doc/mctrl.md
MCTRL -- requirements
Module: mctrl

Interface
REQ-001 SHALL have ports `clk  input  1  clock`; all state changes occur on its rising edge.
REQ-002 SHALL have ports `rst  input  1  reset`; synchronous, active-high.
REQ-003 `Opcode  input  6`: instruction bits [31:26] from the instruction register; stable from DECODE until the next FETCH.
REQ-004 `Zero  input  1`: ALU zero flag.
REQ-005 `mem_ready  input  1`: memory has completed the current read/write this cycle.
REQ-006 `PCWrite  output  1`: unconditional PC load.
REQ-007 `Branch  output  1`: PC load qualified by Zero.
REQ-008 `PCSource  output  2`: 00 ALU result, 01 ALUOut register, 10 jump target.
REQ-009 `IorD  output  1`: memory address select; 0 PC, 1 ALUOut.
REQ-010 `MemRead  output  1`: memory read strobe.
REQ-011 `MemWrite  output  1`: memory write strobe.
REQ-012 `IRWrite  output  1`: instruction register load.
REQ-013 `RegDst  output  1`: register destination; 1 rd, 0 rt.
REQ-014 `MemtoReg  output  1`: writeback source; 1 MDR, 0 ALUOut.
REQ-015 `RegWrite  output  1`: register file write enable.
REQ-016 `ALUSrcA  output  1`: ALU A input; 0 PC, 1 rs.
REQ-017 `ALUSrcB  output  2`: ALU B input; 00 rt, 01 constant 4, 10 extended imm, 11 extended imm<<2.
REQ-018 `ALUOp  output  3`: 000 add, 001 sub, 010 funct, 011 lui, 100 or, 111 illegal.
REQ-019 `Ext_op  output  1`: immediate extension; 1 sign, 0 zero.
REQ-020 `illegal  output  1`: sticky illegal-opcode flag.
REQ-021 `state  output  4`: current state, for debug.

Function
REQ-022 SHALL be a Moore FSM; outputs SHALL decode from state (plus Opcode in IEXE); any output not listed for a state SHALL be 0.
REQ-023 FETCH(0): MemRead, ALUSrcB=01, ALUOp=000. If mem_ready: IRWrite, PCWrite, PCSource=00, next DECODE; else hold.
REQ-024 DECODE(1): ALUSrcB=11, Ext_op=1. Next state by Opcode:
- LW(100011) or SW(101011): MEMADR
- R(000000): REXE
- ADDI(001000), ADDIU(001001), LUI(001111), ORI(001101): IEXE
- BEQ(000100): BR
- J(000010): JMP
- any other opcode: ILLEGAL
REQ-025 MEMADR(2): ALUSrcA=1, ALUSrcB=10, Ext_op=1; next MEMRD if LW, MEMWR if SW.
REQ-026 MEMRD(3): MemRead, IorD=1; next LWB on mem_ready, else hold.
REQ-027 LWB(4): RegWrite, MemtoReg=1, RegDst=0; next FETCH.
REQ-028 MEMWR(5): MemWrite, IorD=1; next FETCH on mem_ready, else hold. MemWrite SHALL stay asserted throughout the hold.
REQ-029 REXE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=010; next RWB.
REQ-030 RWB(7): RegWrite, RegDst=1; next FETCH.
REQ-031 IEXE(8): ALUSrcA=1, ALUSrcB=10. ALUOp is 000 for ADDI/ADDIU, 011 for LUI, 100 for ORI. Ext_op is 1 for ADDI/ADDIU, 0 for LUI/ORI. Next IWB.
REQ-032 IWB(9): RegWrite, RegDst=0, MemtoReg=0; next FETCH.
REQ-033 BR(10): ALUSrcA=1, ALUSrcB=00, ALUOp=001, Branch=1, PCSource=01; next FETCH. The PC loads only when Zero=1.
REQ-034 JMP(11): PCWrite, PCSource=10; next FETCH.
REQ-035 ILLEGAL(15): ALUOp=111, illegal=1, all strobes 0; the FSM SHALL stay in ILLEGAL until rst.
REQ-036 Encodings 12–14 are unused; if reached, next state SHALL be ILLEGAL.
REQ-037 Latency with mem_ready=1: LW 5 cycles; SW, R, I-type 4; BEQ, J 3. Each stall cycle adds 1.

Reset
REQ-038 While rst=1, the FSM SHALL load FETCH on the clock edge and illegal SHALL clear.
REQ-039 While rst=1, MemRead, MemWrite, IRWrite, PCWrite, Branch and RegWrite SHALL be forced to 0, regardless of the current state.
REQ-040 rst asserted mid-instruction (including during a memory hold) SHALL abort the instruction; no strobe may be issued in that cycle.

Structure
REQ-041 Package mctrl_pkg SHALL hold:
- state encodings
- opcode constants
- ALUOp codes
- ALUSrcB and PCSource select codes
REQ-042 The state/opcode-to-signal decoding SHALL be placed in combinational sub-module mctrl_dec; mctrl holds only the state register and next-state logic.

Verification
REQ-043 rst held 2 cycles, then released, with mem_ready=1 and Opcode=000000 → states 0,1,6,7,0. RegWrite=1 with RegDst=1 only in state 7.
REQ-044 Opcode=100011, mem_ready low for 3 cycles in MEMRD → state 3 held 3 cycles with MemRead=1 and IorD=1; then LWB with MemtoReg=1, then FETCH.
REQ-045 Opcode=000100 run twice, Zero=1 then Zero=0 → in BR, Branch=1, PCSource=01, ALUOp=001 both times; the PC-load condition is true only for the Zero=1 run.
REQ-046 Opcode=001101 then 001111 → in IEXE, ALUOp=100 with Ext_op=0, then ALUOp=011 with Ext_op=0. Opcode=001001 → ALUOp=000 with Ext_op=1.
REQ-047 Opcode=111111 → ILLEGAL reached after DECODE; illegal=1 and all strobes 0 for 10+ cycles. rst then returns state to 0 and clears illegal.
REQ-048 rst asserted in MEMWR while mem_ready=0 → MemWrite=0 in that cycle; state=0 on the next cycle.
